// File: rtl/sprite_palette_pkg.sv
// Shared types and reset contents for the sprite palette bank.
// The 16-entry default palette is stored entry 0 in the least significant slot.
package sprite_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t [15:0] DEFAULT_PALETTE = {
        12'h444, 12'h210, 12'h010, 12'h030, 12'h222, 12'h063, 12'hDB9, 12'h430,
        12'h020, 12'h950, 12'h084, 12'h986, 12'h630, 12'h041, 12'h000, 12'hE00
    };

    // Entries beyond the 16 defined colours reset to black.
    function automatic rgb12_t default_entry(input int idx);
        logic [3:0] slot;
        slot = idx[3:0];
        return (idx < 16) ? DEFAULT_PALETTE[slot] : '0;
    endfunction

endpackage

// File: rtl/palette_blink_timer.sv
// Frame-counting blink timer: the phase toggles every BLINK_FRAMES frame_start pulses
// while blinking is enabled, and drops back to OFF as soon as blinking is disabled.
module palette_blink_timer #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_start,
    input  logic blink_en,
    output logic phase
);

    localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] cnt;

    always_ff @(posedge Clk) begin
        if (!Reset_n || !blink_en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (frame_start) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_palette_bank.sv
// Banked 12-bit sprite palette with frame-synchronous bank switching and blink alternation.
// Storage is flip-flops so every bank can be restored to the default palette on reset.
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W        = 4,
    parameter int NUM_BANKS    = 4,
    parameter int BLINK_FRAMES = 16,
    parameter int TRANSP_IDX   = 0,
    localparam int BW          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_start,
    input  logic [BW-1:0]    bank_sel,
    input  logic             blink_en,
    input  logic [BW-1:0]    blink_bank,
    input  logic             pix_valid,
    input  logic [IDX_W-1:0] index,
    input  logic             wr_en,
    input  logic [BW-1:0]    wr_bank,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [11:0]      wr_data,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             out_valid,
    output logic             transparent
);

    localparam int               DEPTH = 1 << IDX_W;
    localparam logic [BW:0]      NB    = (BW + 1)'(NUM_BANKS);
    localparam logic [IDX_W-1:0] TIDX  = IDX_W'(TRANSP_IDX);

    logic                          phase;
    logic [BW-1:0]                 active_bank;
    logic [BW-1:0]                 disp_bank;
    rgb12_t [NUM_BANKS-1:0]        bank_rd;
    rgb12_t                        rdata;

    palette_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .blink_en    (blink_en),
        .phase       (phase)
    );

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rgb12_t ent [DEPTH];

        // Reset wins over a concurrent write; out-of-range wr_bank matches no bank.
        always_ff @(posedge Clk) begin
            if (!Reset_n) begin
                for (int i = 0; i < DEPTH; i++)
                    ent[i] <= default_entry(i);
            end else if (wr_en && wr_bank == BW'(b)) begin
                ent[wr_addr] <= rgb12_t'(wr_data);
            end
        end

        assign bank_rd[b] = ent[index];
    end

    // Read sees pre-edge state, so same-cycle writes and bank/phase updates are not visible yet.
    always_comb begin
        disp_bank = (blink_en && phase) ? blink_bank : active_bank;
        rdata     = '0;
        if ({1'b0, disp_bank} < NB)
            rdata = bank_rd[disp_bank];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid   <= 1'b0;
            transparent <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            active_bank <= '0;
        end else begin
            out_valid   <= pix_valid;
            transparent <= pix_valid && (index == TIDX);
            red         <= pix_valid ? rdata.r : 4'h0;
            green       <= pix_valid ? rdata.g : 4'h0;
            blue        <= pix_valid ? rdata.b : 4'h0;
            if (frame_start && {1'b0, bank_sel} < NB)
                active_bank <= bank_sel;
        end
    end

endmodule
